// File: rtl/tpm_fifo_regs.sv
// TPM 2.0 FIFO (PTP) register file on the byte-wide LPC/SPI data-provider port.
// Decodes {locality, offset}, serves one byte per handshake and drives SIRQ vector / interrupt.
module tpm_fifo_regs #(
    parameter logic [31:0] DID_VID = 32'h0001_1B4E,
    parameter logic [7:0]  RID     = 8'h00
) (
    input  logic        clk_i,
    input  logic        rst_i,
    inout  wire  [7:0]  data_io,
    input  logic [15:0] addr_i,
    input  logic        data_wr,
    output logic        wr_done,
    output logic        data_rd,
    input  logic        data_req,
    output logic [3:0]  irq_num,
    output logic        interrupt
);

    localparam int unsigned LOC_W  = 4;
    localparam int unsigned OFF_W  = 12;
    localparam int unsigned WORD_W = OFF_W - 2;
    localparam int unsigned BYTE_W = 8;

    localparam logic [LOC_W-1:0]  MAX_LOC     = 4'd4;
    localparam logic [WORD_W-1:0] W_ACCESS    = 10'h000;
    localparam logic [WORD_W-1:0] W_INT_EN    = 10'h002;
    localparam logic [WORD_W-1:0] W_INT_VEC   = 10'h003;
    localparam logic [WORD_W-1:0] W_INT_STS   = 10'h004;
    localparam logic [WORD_W-1:0] W_INTF_CAP  = 10'h005;
    localparam logic [WORD_W-1:0] W_DID_VID   = 10'h3C0;
    localparam logic [WORD_W-1:0] W_RID       = 10'h3C1;
    localparam logic [31:0]       INTF_CAP    = 32'h0000_0004;
    localparam logic [BYTE_W-1:0] INT_EN_LO_M = 8'h87;
    localparam logic [BYTE_W-1:0] UNMAPPED    = 8'hFF;

    logic              act_vld_q, act_vld_d;
    logic [LOC_W-1:0]  act_loc_q, act_loc_d;
    logic [31:0]       int_en_q, int_en_d;
    logic [3:0]        sirq_q, sirq_d;
    logic              sts_q, sts_d;
    logic              wr_done_q, wr_done_d;
    logic              data_rd_q, data_rd_d;
    logic [BYTE_W-1:0] rd_data_q, rd_data_d;
    logic              irq_q, irq_d;

    logic [LOC_W-1:0]  loc_c;
    logic [WORD_W-1:0] word_c;
    logic [1:0]        byte_sel_c;
    logic [4:0]        bit_ofs_c;
    logic              loc_ok_c;
    logic              is_active_c;
    logic [BYTE_W-1:0] wdata_c;
    logic [31:0]       sts_word_c;
    logic [BYTE_W-1:0] rd_byte_c;
    logic              wr_fire_c;

    // Address split and shared decode terms
    always_comb begin
        loc_c       = addr_i[15:12];
        word_c      = addr_i[OFF_W-1:2];
        byte_sel_c  = addr_i[1:0];
        bit_ofs_c   = {byte_sel_c, 3'b000};
        loc_ok_c    = (loc_c <= MAX_LOC);
        is_active_c = act_vld_q && (act_loc_q == loc_c);
        wdata_c     = data_io;
        sts_word_c  = {29'd0, sts_q, 2'd0};
        wr_fire_c   = data_wr && !wr_done_q;
    end

    // Read byte mux; anything not decoded reads all-ones
    always_comb begin
        rd_byte_c = UNMAPPED;
        if (loc_ok_c) begin
            case (word_c)
                W_ACCESS: begin
                    if (byte_sel_c == 2'd0) begin
                        rd_byte_c = {1'b1, 1'b0, is_active_c, 5'd0};
                    end
                end
                W_INT_EN:   rd_byte_c = int_en_q[bit_ofs_c +: BYTE_W];
                W_INT_VEC: begin
                    if (byte_sel_c == 2'd0) begin
                        rd_byte_c = {4'd0, sirq_q};
                    end
                end
                W_INT_STS:  rd_byte_c = sts_word_c[bit_ofs_c +: BYTE_W];
                W_INTF_CAP: rd_byte_c = INTF_CAP[bit_ofs_c +: BYTE_W];
                W_DID_VID:  rd_byte_c = DID_VID[bit_ofs_c +: BYTE_W];
                W_RID: begin
                    if (byte_sel_c == 2'd0) begin
                        rd_byte_c = RID;
                    end
                end
                default:    rd_byte_c = UNMAPPED;
            endcase
        end
    end

    // Handshake sequencing and register updates
    always_comb begin
        act_vld_d = act_vld_q;
        act_loc_d = act_loc_q;
        int_en_d  = int_en_q;
        sirq_d    = sirq_q;
        sts_d     = sts_q;
        rd_data_d = rd_data_q;
        wr_done_d = data_wr;
        data_rd_d = data_rd_q;
        irq_d     = int_en_q[31] && |(sts_word_c[BYTE_W-1:0] & int_en_q[BYTE_W-1:0]);

        // A pending write takes precedence; a new read waits until data_wr drops
        if (data_rd_q) begin
            data_rd_d = data_req;
        end else if (data_req && !data_wr) begin
            data_rd_d = 1'b1;
            rd_data_d = rd_byte_c;
        end

        if (wr_fire_c && loc_ok_c) begin
            case (word_c)
                W_ACCESS: begin
                    if (byte_sel_c == 2'd0) begin
                        if (wdata_c[5] && is_active_c) begin
                            act_vld_d = 1'b0;
                        end else if (wdata_c[1] && !act_vld_q) begin
                            act_vld_d = 1'b1;
                            act_loc_d = loc_c;
                            sts_d     = 1'b1;
                        end
                    end
                end
                W_INT_EN: begin
                    if (byte_sel_c == 2'd0) begin
                        int_en_d[BYTE_W-1:0] = wdata_c & INT_EN_LO_M;
                    end else if (byte_sel_c == 2'd3) begin
                        int_en_d[31] = wdata_c[7];
                    end
                end
                W_INT_VEC: begin
                    if (byte_sel_c == 2'd0) begin
                        sirq_d = wdata_c[3:0];
                    end
                end
                W_INT_STS: begin
                    if ((byte_sel_c == 2'd0) && wdata_c[2]) begin
                        sts_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act_vld_q <= 1'b0;
            act_loc_q <= '0;
            int_en_q  <= '0;
            sirq_q    <= '0;
            sts_q     <= 1'b0;
            wr_done_q <= 1'b0;
            data_rd_q <= 1'b0;
            rd_data_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            act_vld_q <= act_vld_d;
            act_loc_q <= act_loc_d;
            int_en_q  <= int_en_d;
            sirq_q    <= sirq_d;
            sts_q     <= sts_d;
            wr_done_q <= wr_done_d;
            data_rd_q <= data_rd_d;
            rd_data_q <= rd_data_d;
            irq_q     <= irq_d;
        end
    end

    assign data_io   = data_rd_q ? rd_data_q : 8'hzz;
    assign wr_done   = wr_done_q;
    assign data_rd   = data_rd_q;
    assign irq_num   = sirq_q;
    assign interrupt = irq_q;

endmodule

// File: tb/tb_tpm_fifo_regs.sv
// Directed and randomized checks of tpm_fifo_regs against a byte-level model of the register map.
module tb_tpm_fifo_regs;

    localparam logic [31:0] DID_VID_EXP = 32'h0001_1B4E;

    logic        clk = 1'b0;
    logic        rst_i;
    wire  [7:0]  data_io;
    logic [15:0] addr;
    logic        data_wr;
    logic        wr_done;
    logic        data_rd;
    logic        data_req;
    logic [3:0]  irq_num;
    logic        interrupt;
    logic [7:0]  tb_drv;
    logic        tb_en;

    int checks   = 0;
    int failures = 0;

    // Model state
    int          m_act;
    logic [31:0] m_en;
    logic [3:0]  m_vec;
    logic        m_sts;

    int unsigned offs [20] = '{12'h000, 12'h000, 12'h008, 12'h009, 12'h00A, 12'h00B,
                               12'h00C, 12'h00D, 12'h010, 12'h011, 12'h013, 12'h014,
                               12'h017, 12'hF00, 12'hF03, 12'hF04, 12'hF06, 12'h004,
                               12'h7FF, 12'h00B};

    assign data_io = tb_en ? tb_drv : 8'hzz;

    always #5 clk = ~clk;

    tpm_fifo_regs dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .data_io   (data_io),
        .addr_i    (addr),
        .data_wr   (data_wr),
        .wr_done   (wr_done),
        .data_rd   (data_rd),
        .data_req  (data_req),
        .irq_num   (irq_num),
        .interrupt (interrupt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_act = -1;
        m_en  = 32'd0;
        m_vec = 4'd0;
        m_sts = 1'b0;
    endfunction

    function automatic logic [7:0] m_read(input logic [15:0] a);
        int          loc = int'(a[15:12]);
        int          off = int'(a[11:0]);
        int          b   = off % 4;
        logic [31:0] w;
        if (loc > 4) return 8'hFF;
        if (off == 0) return (m_act == loc) ? 8'hA0 : 8'h80;
        if (off == 12) return {4'h0, m_vec};
        if (off == 12'hF04) return 8'h00;
        if (off >= 8 && off <= 11) w = m_en;
        else if (off >= 16 && off <= 19) w = m_sts ? 32'd4 : 32'd0;
        else if (off >= 20 && off <= 23) w = 32'd4;
        else if (off >= 12'hF00 && off <= 12'hF03) w = DID_VID_EXP;
        else return 8'hFF;
        return 8'(w >> (8 * b));
    endfunction

    function automatic void m_write(input logic [15:0] a, input logic [7:0] d);
        int loc = int'(a[15:12]);
        int off = int'(a[11:0]);
        if (loc > 4) return;
        if (off == 0) begin
            if (d[5] && m_act == loc) m_act = -1;
            else if (d[1] && m_act < 0) begin
                m_act = loc;
                m_sts = 1'b1;
            end
        end
        if (off == 8) m_en[7:0] = d & 8'h87;
        if (off == 11) m_en[31] = d[7];
        if (off == 12) m_vec = d[3:0];
        if (off == 16 && d[2]) m_sts = 1'b0;
    endfunction

    function automatic logic m_irq();
        return m_en[31] && m_sts && m_en[2];
    endfunction

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        int n;
        @(negedge clk);
        addr    = a;
        tb_drv  = d;
        tb_en   = 1'b1;
        data_wr = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wr_done && n < 20);
        check("wr_done_rise", 32'(wr_done), 32'd1);
        m_write(a, d);
        data_wr = 1'b0;
        tb_en   = 1'b0;
        @(negedge clk);
        check("wr_done_fall", 32'(wr_done), 32'd0);
    endtask

    task automatic do_read(input logic [15:0] a, output logic [7:0] d);
        int n;
        @(negedge clk);
        addr     = a;
        data_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!data_rd && n < 20);
        check("data_rd_rise", 32'(data_rd), 32'd1);
        d = data_io;
        data_req = 1'b0;
        @(negedge clk);
        check("data_rd_fall", 32'(data_rd), 32'd0);
    endtask

    initial begin
        logic [7:0]  rb;
        logic [31:0] dv;
        logic [15:0] ra;
        logic [7:0]  rd8;
        int          n;
        int          r;

        rst_i    = 1'b1;
        addr     = 16'h0;
        data_wr  = 1'b0;
        data_req = 1'b0;
        tb_en    = 1'b0;
        tb_drv   = 8'h00;
        m_reset();
        repeat (3) @(negedge clk);
        check("rst_wr_done", 32'(wr_done), 32'd0);
        check("rst_data_rd", 32'(data_rd), 32'd0);
        check("rst_irq_num", 32'(irq_num), 32'd0);
        check("rst_interrupt", 32'(interrupt), 32'd0);
        rst_i = 1'b0;

        // Identification registers
        dv = 32'd0;
        for (int i = 0; i < 4; i++) begin
            do_read(16'hF00 + 16'(i), rb);
            dv[8*i +: 8] = rb;
        end
        check("did_vid", dv, DID_VID_EXP);
        do_read(16'hF04, rb);
        check("rid", 32'(rb), 32'h00);
        do_read(16'hF05, rb);
        check("rid_pad", 32'(rb), 32'hFF);

        // Interrupt vector, including reserved bits
        do_write(16'h000C, 8'h05);
        check("irq_num_5", 32'(irq_num), 32'h5);
        do_read(16'h000C, rb);
        check("vec_rd_05", 32'(rb), 32'h05);
        do_write(16'h000C, 8'hFA);
        check("irq_num_a", 32'(irq_num), 32'hA);
        do_read(16'h000C, rb);
        check("vec_rd_0a", 32'(rb), 32'h0A);
        do_write(16'h500C, 8'h03);
        check("loc5_wr_ignored", 32'(irq_num), 32'hA);

        // Locality grant raises the locality-change interrupt
        do_write(16'h000B, 8'h80);
        do_write(16'h0008, 8'h04);
        check("irq_before_grant", 32'(interrupt), 32'd0);
        do_write(16'h0000, 8'h02);
        do_read(16'h0000, rb);
        check("access_granted", 32'(rb), 32'hA0);
        do_read(16'h0010, rb);
        check("int_sts_set", 32'(rb), 32'h04);
        check("irq_asserted", 32'(interrupt), 32'd1);

        do_write(16'h0010, 8'h04);
        do_read(16'h0010, rb);
        check("int_sts_clr", 32'(rb), 32'h00);
        check("irq_cleared", 32'(interrupt), 32'd0);
        do_write(16'h1000, 8'h02);
        do_read(16'h1000, rb);
        check("loc1_not_granted", 32'(rb & 8'hA0), 32'h80);
        do_read(16'h0000, rb);
        check("loc0_still_active", 32'(rb), 32'hA0);
        do_read(16'h5F00, rb);
        check("loc5_read_ff", 32'(rb), 32'hFF);

        // Reset in the middle of a read handshake
        @(negedge clk);
        addr     = 16'hF05;
        data_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!data_rd && n < 20);
        check("mid_rd_active", 32'(data_rd), 32'd1);
        check("mid_rd_data", 32'(data_io), 32'hFF);
        #2;
        rst_i = 1'b1;
        #1;
        check("abort_data_rd", 32'(data_rd), 32'd0);
        check("abort_irq_num", 32'(irq_num), 32'd0);
        check("abort_interrupt", 32'(interrupt), 32'd0);
        data_req = 1'b0;
        tb_drv   = 8'h5A;
        tb_en    = 1'b1;
        #1;
        check("abort_bus_released", 32'(data_io), 32'h5A);
        tb_en = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        m_reset();

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            r  = int'($urandom_range(0, 9));
            ra[15:12] = (r < 8) ? 4'(r % 5) : 4'($urandom_range(5, 15));
            ra[11:0]  = 12'(offs[$urandom_range(0, 19)]);
            if ($urandom_range(0, 1) == 1) begin
                rd8 = 8'($urandom);
                do_write(ra, rd8);
                check("rnd_irq_num", 32'(irq_num), 32'(m_vec));
                check("rnd_interrupt", 32'(interrupt), 32'(m_irq()));
            end else begin
                do_read(ra, rb);
                check("rnd_read", 32'(rb), 32'(m_read(ra)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
